// File: rtl/zeroheti_obi_demux.sv
// Single-master, N-slave OBI request demultiplexer with in-order response tracking.
// Build option: define ZEROHETI_DEMUX_ERR_RESP_EN to answer unmapped accesses internally with an error.

package zeroheti_pkg;
    typedef struct packed {
        logic [31:0] base;
        logic [31:0] last;
    } addr_rule_t;

    localparam addr_rule_t DbgAddr    = '{base: 32'h0000_0000, last: 32'h0000_1000};
    localparam addr_rule_t HetIcAddr  = '{base: 32'h0000_1000, last: 32'h0000_2000};
    localparam addr_rule_t UartAddr   = '{base: 32'h0000_2000, last: 32'h0000_2100};
    localparam addr_rule_t MtimerAddr = '{base: 32'h0000_2100, last: 32'h0000_2200};
    localparam addr_rule_t ImemAddr   = '{base: 32'h0001_0000, last: 32'h0002_0000};
    localparam addr_rule_t DmemAddr   = '{base: 32'h0002_0000, last: 32'h0003_0000};
    localparam addr_rule_t ExtAddr    = '{base: 32'h8000_0000, last: 32'hFFFF_FFFF};
endpackage

module zeroheti_obi_demux #(
    parameter int unsigned NumRules = 7,
    parameter zeroheti_pkg::addr_rule_t Rules [NumRules] = '{
        zeroheti_pkg::DbgAddr, zeroheti_pkg::HetIcAddr, zeroheti_pkg::UartAddr,
        zeroheti_pkg::MtimerAddr, zeroheti_pkg::ImemAddr, zeroheti_pkg::DmemAddr,
        zeroheti_pkg::ExtAddr},
    parameter int unsigned MaxTrans = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [31:0]              addr_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              wdata_i,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic [NumRules-1:0]      dn_req_o,
    input  logic [NumRules-1:0]      dn_gnt_i,
    output logic [31:0]              dn_addr_o,
    output logic                     dn_we_o,
    output logic [3:0]               dn_be_o,
    output logic [31:0]              dn_wdata_o,
    input  logic [NumRules-1:0]      dn_rvalid_i,
    input  logic [NumRules-1:0][31:0] dn_rdata_i,
    input  logic [NumRules-1:0]      dn_err_i,
    output logic                     unmapped_o
);

    localparam int unsigned CntW = $clog2(MaxTrans + 1);
    localparam int unsigned SelW = $clog2(NumRules + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MaxTrans);
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
    localparam logic [SelW-1:0] ErrSel  = SelW'(NumRules);
    localparam logic [31:0]     ErrData = 32'hBADC_AB1E;
    logic err_pending_q;
`endif

    logic [CntW-1:0]     cnt_q, cnt_next;
    logic [SelW-1:0]     sel_q;
    logic [NumRules-1:0] hit;
    logic                mapped;
    logic [SelW-1:0]     hit_idx, target;
    logic                issue, hs, active;
    logic                port_gnt, port_rvalid, port_err;
    logic [31:0]         port_rdata;

    generate
        for (genvar gi = 0; gi < NumRules; gi++) begin : g_decode
            assign hit[gi]      = (addr_i >= Rules[gi].base) && (addr_i < Rules[gi].last);
            assign dn_req_o[gi] = issue && (target == SelW'(gi));
        end
    endgenerate

    // Scan downward so the lowest matching rule wins on overlap.
    always_comb begin
        mapped  = 1'b0;
        hit_idx = '0;
        for (int i = int'(NumRules) - 1; i >= 0; i--) begin
            if (hit[i]) begin
                mapped  = 1'b1;
                hit_idx = SelW'(i);
            end
        end
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        target = mapped ? hit_idx : ErrSel;
`else
        target = mapped ? hit_idx : SelW'(NumRules - 1);
`endif
    end

    always_comb begin
        port_gnt    = 1'b0;
        port_rvalid = 1'b0;
        port_rdata  = '0;
        port_err    = 1'b0;
        for (int i = 0; i < int'(NumRules); i++) begin
            if (target == SelW'(i)) begin
                port_gnt = dn_gnt_i[i];
            end
            if (sel_q == SelW'(i)) begin
                port_rvalid = dn_rvalid_i[i];
                port_rdata  = dn_rdata_i[i];
                port_err    = dn_err_i[i];
            end
        end
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        if (target == ErrSel) begin
            port_gnt = 1'b1;
        end
        if (sel_q == ErrSel) begin
            port_rvalid = err_pending_q;
            port_rdata  = ErrData;
            port_err    = 1'b1;
        end
`endif
    end

    // A new target is only accepted once every outstanding response has drained.
    assign issue  = req_i && (cnt_q < MaxCnt) && ((cnt_q == '0) || (target == sel_q));
    assign gnt_o  = issue && port_gnt;
    assign hs     = req_i && gnt_o;
    assign active = (cnt_q != '0);

    assign rvalid_o   = active && port_rvalid;
    assign rdata_o    = active ? port_rdata : 32'h0;
    assign err_o      = rvalid_o && port_err;
    assign unmapped_o = hs && !mapped;

    assign dn_addr_o  = addr_i;
    assign dn_we_o    = we_i;
    assign dn_be_o    = be_i;
    assign dn_wdata_o = wdata_i;

    always_comb begin
        cnt_next = cnt_q;
        case ({hs, rvalid_o})
            2'b10:   cnt_next = cnt_q + CntW'(1);
            2'b01:   cnt_next = cnt_q - CntW'(1);
            default: cnt_next = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            sel_q <= '0;
        end else begin
            cnt_q <= cnt_next;
            if (hs) begin
                sel_q <= target;
            end
        end
    end

`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
    // The internal error responder answers exactly one cycle after each handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_pending_q <= 1'b0;
        end else begin
            err_pending_q <= hs && (target == ErrSel);
        end
    end
`endif

endmodule

// File: tb/tb_zeroheti_obi_demux.sv
// Directed bench for zeroheti_obi_demux: decode, stalls, ordering, unmapped handling and reset.
module tb_zeroheti_obi_demux;

    logic              clk = 1'b0;
    logic              rst;
    logic              req;
    logic              gnt;
    logic [31:0]       addr;
    logic              we;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;
    logic [6:0]        dn_req;
    logic [6:0]        dn_gnt;
    logic [31:0]       dn_addr;
    logic              dn_we;
    logic [3:0]        dn_be;
    logic [31:0]       dn_wdata;
    logic [6:0]        dn_rvalid;
    logic [6:0][31:0]  dn_rdata;
    logic [6:0]        dn_err;
    logic              unmapped;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    zeroheti_obi_demux dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .gnt_o       (gnt),
        .addr_i      (addr),
        .we_i        (we),
        .be_i        (be),
        .wdata_i     (wdata),
        .rvalid_o    (rvalid),
        .rdata_o     (rdata),
        .err_o       (err),
        .dn_req_o    (dn_req),
        .dn_gnt_i    (dn_gnt),
        .dn_addr_o   (dn_addr),
        .dn_we_o     (dn_we),
        .dn_be_o     (dn_be),
        .dn_wdata_o  (dn_wdata),
        .dn_rvalid_i (dn_rvalid),
        .dn_rdata_i  (dn_rdata),
        .dn_err_i    (dn_err),
        .unmapped_o  (unmapped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // Response scoreboard: every upstream rvalid must match the oldest expected response.
    always @(negedge clk) begin
        if (!rst && rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rvalid", 32'(rvalid), 32'h0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("resp_rdata", rdata, e.rdata);
                check("resp_err", 32'(err), 32'(e.err));
                $display("[TB] t=%0t resp rdata=%h err=%0b", $time, rdata, err);
            end
        end
    end

    initial begin
        rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = 4'hF; wdata = '0;
        dn_gnt = '0; dn_rvalid = '0; dn_rdata = '0; dn_err = '0;
        tick(); tick(); settle();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_rvalid", 32'(rvalid), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_unmapped", 32'(unmapped), 32'h0);
        check("rst_dn_req", 32'(dn_req), 32'h0);
        check("rst_rdata", rdata, 32'h0);
        check("rst_cnt", 32'(dut.cnt_q), 32'h0);
        tick(); rst = 1'b0;

        // uart read, slave answers two cycles after the grant
        tick(); req = 1'b1; addr = 32'h0000_2004; dn_gnt = 7'b000_0100; settle();
        check("uart_dn_req", 32'(dn_req), 32'h04);
        check("uart_gnt", 32'(gnt), 32'h1);
        check("uart_addr_bcast", dn_addr, 32'h0000_2004);
        check("uart_cnt0", 32'(dut.cnt_q), 32'h0);
        exp_q.push_back('{rdata: 32'h55, err: 1'b0});
        $display("[TB] t=%0t req uart addr=%h", $time, addr);
        tick(); req = 1'b0; dn_gnt = '0; settle();
        check("uart_cnt1", 32'(dut.cnt_q), 32'h1);
        check("uart_wait_rvalid", 32'(rvalid), 32'h0);
        tick(); dn_rvalid[2] = 1'b1; dn_rdata[2] = 32'h55; settle();
        check("uart_rvalid", 32'(rvalid), 32'h1);
        tick(); dn_rvalid = '0; settle();
        check("uart_cnt_done", 32'(dut.cnt_q), 32'h0);

        // Decode boundaries, no grant so nothing is accepted
        req = 1'b1; addr = 32'h0000_1000; settle();
        check("dec_1000_hetic", 32'(dn_req), 32'h02);
        addr = 32'h0000_0FFC; settle();
        check("dec_0ffc_dbg", 32'(dn_req), 32'h01);
        addr = 32'h0000_2114; settle();
        check("dec_2114_mtimer", 32'(dn_req), 32'h08);
        addr = 32'h0001_FFFF; settle();
        check("dec_1ffff_imem", 32'(dn_req), 32'h10);
        addr = 32'h0002_0000; settle();
        check("dec_20000_dmem", 32'(dn_req), 32'h20);
        check("dec_no_gnt", 32'(gnt), 32'h0);
        req = 1'b0;

        // Back-to-back imem reads, latency 3, MaxTrans 2
        tick(); req = 1'b1; addr = 32'h0001_0000; dn_gnt = 7'b001_0000; settle();
        check("b2b_gnt1", 32'(gnt), 32'h1);
        exp_q.push_back('{rdata: 32'hA1, err: 1'b0});
        $display("[TB] t=%0t req imem addr=%h", $time, addr);
        tick(); addr = 32'h0001_0004; settle();
        check("b2b_gnt2", 32'(gnt), 32'h1);
        check("b2b_cnt1", 32'(dut.cnt_q), 32'h1);
        exp_q.push_back('{rdata: 32'hA2, err: 1'b0});
        $display("[TB] t=%0t req imem addr=%h", $time, addr);
        tick(); addr = 32'h0001_0008; settle();
        check("b2b_stall_gnt", 32'(gnt), 32'h0);
        check("b2b_stall_req", 32'(dn_req), 32'h0);
        check("b2b_cnt2", 32'(dut.cnt_q), 32'h2);
        tick(); dn_rvalid[4] = 1'b1; dn_rdata[4] = 32'hA1; settle();
        check("b2b_full_gnt", 32'(gnt), 32'h0);
        check("b2b_rv1", 32'(rvalid), 32'h1);
        tick(); dn_rdata[4] = 32'hA2; settle();
        check("b2b_gnt3", 32'(gnt), 32'h1);
        check("b2b_cnt_before", 32'(dut.cnt_q), 32'h1);
        exp_q.push_back('{rdata: 32'hA3, err: 1'b0});
        $display("[TB] t=%0t req imem addr=%h", $time, addr);
        tick(); req = 1'b0; dn_rvalid = '0; settle();
        check("b2b_cnt_same", 32'(dut.cnt_q), 32'h1);
        tick();
        tick(); dn_rvalid[4] = 1'b1; dn_rdata[4] = 32'hA3; settle();
        check("b2b_rv3", 32'(rvalid), 32'h1);
        tick(); dn_rvalid = '0; settle();
        check("b2b_cnt_done", 32'(dut.cnt_q), 32'h0);

        // Target switch waits for the imem response to drain
        tick(); req = 1'b1; addr = 32'h0001_0010; dn_gnt = '1; settle();
        check("sw_imem_req", 32'(dn_req), 32'h10);
        exp_q.push_back('{rdata: 32'hB1, err: 1'b0});
        $display("[TB] t=%0t req imem addr=%h", $time, addr);
        tick(); addr = 32'h0002_0000; settle();
        check("sw_hold_req", 32'(dn_req), 32'h0);
        check("sw_hold_gnt", 32'(gnt), 32'h0);
        tick(); settle();
        check("sw_hold_req2", 32'(dn_req), 32'h0);
        tick(); dn_rvalid[4] = 1'b1; dn_rdata[4] = 32'hB1; settle();
        check("sw_resp_req", 32'(dn_req), 32'h0);
        tick(); dn_rvalid = '0; settle();
        check("sw_dmem_req", 32'(dn_req), 32'h20);
        check("sw_dmem_gnt", 32'(gnt), 32'h1);
        exp_q.push_back('{rdata: 32'hB2, err: 1'b1});
        $display("[TB] t=%0t req dmem addr=%h", $time, addr);
        tick(); req = 1'b0; dn_rvalid[5] = 1'b1; dn_rdata[5] = 32'hB2; dn_err[5] = 1'b1;
        dn_rvalid[4] = 1'b1; dn_rdata[4] = 32'hDEAD; settle();
        check("sw_dmem_rdata", rdata, 32'hB2);
        check("sw_dmem_err", 32'(err), 32'h1);
        tick(); dn_rvalid = '1; dn_err = '0; settle();
        check("sw_idle_stray", 32'(rvalid), 32'h0);
        check("sw_cnt_done", 32'(dut.cnt_q), 32'h0);
        tick(); dn_rvalid = '0;

        // Unmapped write into the gap at 0x3000
        tick(); req = 1'b1; we = 1'b1; addr = 32'h0000_3000; wdata = 32'h1234_5678; dn_gnt = '1; settle();
        check("unm_gnt", 32'(gnt), 32'h1);
        check("unm_pulse", 32'(unmapped), 32'h1);
`ifdef ZEROHETI_DEMUX_ERR_RESP_EN
        check("unm_no_dn_req", 32'(dn_req), 32'h0);
        exp_q.push_back('{rdata: 32'hBADC_AB1E, err: 1'b1});
        $display("[TB] t=%0t req unmapped addr=%h", $time, addr);
        tick(); req = 1'b0; we = 1'b0; settle();
        check("unm_rvalid", 32'(rvalid), 32'h1);
        check("unm_rdata", rdata, 32'hBADC_AB1E);
        check("unm_pulse_end", 32'(unmapped), 32'h0);
        tick(); settle();
        check("unm_rvalid_end", 32'(rvalid), 32'h0);
`else
        check("unm_ext_req", 32'(dn_req), 32'h40);
        exp_q.push_back('{rdata: 32'hC1, err: 1'b0});
        $display("[TB] t=%0t req unmapped addr=%h", $time, addr);
        tick(); req = 1'b0; we = 1'b0; settle();
        check("unm_pulse_end", 32'(unmapped), 32'h0);
        tick(); dn_rvalid[6] = 1'b1; dn_rdata[6] = 32'hC1; settle();
        check("unm_ext_rvalid", 32'(rvalid), 32'h1);
        tick(); dn_rvalid = '0;
`endif
        settle();
        check("unm_cnt_done", 32'(dut.cnt_q), 32'h0);

        // Reset with two outstanding imem transactions
        tick(); req = 1'b1; addr = 32'h0001_0000; dn_gnt = 7'b001_0000;
        tick(); addr = 32'h0001_0004; settle();
        check("rst2_gnt", 32'(gnt), 32'h1);
        tick(); req = 1'b0; dn_gnt = '0; rst = 1'b1; settle();
        check("rst2_cnt_before", 32'(dut.cnt_q), 32'h2);
        tick(); rst = 1'b0; settle();
        check("rst2_cnt", 32'(dut.cnt_q), 32'h0);
        check("rst2_gnt_low", 32'(gnt), 32'h0);
        check("rst2_dn_req", 32'(dn_req), 32'h0);
        check("rst2_rvalid", 32'(rvalid), 32'h0);
        check("rst2_rdata", rdata, 32'h0);
        tick(); dn_rvalid[4] = 1'b1; dn_rdata[4] = 32'h77; settle();
        check("rst2_stray", 32'(rvalid), 32'h0);
        tick(); dn_rvalid = '0;
        tick();

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
